sys_cmd_decoder: RTL and testbench

// - Consumes synchronized UART RX bytes (byte + 1-cycle valid pulse from the RX-domain data synchronizer) in the system clock domain.
// - Parses command frames and drives register-file write/read and ALU operations.
// - Returns read data / ALU results as response bytes over a valid/ready TX handshake.

---
 rtl/sys_cmd_pkg.sv | 27 ++
 rtl/sys_cmd_resp_tx.sv | 46 ++++
 rtl/sys_cmd_decoder.sv | 203 ++++++++++++++++++++
 tb/tb_sys_cmd_decoder.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sys_cmd_pkg.sv
// Shared constants for the system command decoder: opcodes, FSM encoding and the
// register-file addresses that receive the two ALU operands.
package sys_cmd_pkg;

    localparam logic [7:0] OP_WR      = 8'hAA;
    localparam logic [7:0] OP_RD      = 8'hBB;
    localparam logic [7:0] OP_ALU_AB  = 8'hCC;
    localparam logic [7:0] OP_ALU_FUN = 8'hDD;

    localparam int unsigned ALU_A_ADDR = 0;
    localparam int unsigned ALU_B_ADDR = 1;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_WR_ADDR,
        ST_WR_DATA,
        ST_RD_ADDR,
        ST_RD_WAIT,
        ST_ALU_A,
        ST_ALU_B,
        ST_ALU_FUN,
        ST_ALU_WAIT,
        ST_TX_LO,
        ST_TX_HI
    } state_t;

endpackage

// File: rtl/sys_cmd_resp_tx.sv
// Response byte source: holds one byte with valid/ready handshake and, for two-byte
// responses, follows the low byte with the high byte.
module sys_cmd_resp_tx #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    load,
    input  logic                    two_byte,
    input  logic [2*DATA_WIDTH-1:0] load_data,
    input  logic                    abort,
    input  logic                    tx_ready,
    output logic [DATA_WIDTH-1:0]   tx_data,
    output logic                    tx_valid,
    output logic                    xfer,
    output logic                    last
);

    logic [DATA_WIDTH-1:0] hi_q;
    logic                  hi_pend_q;

    assign xfer = tx_valid & tx_ready;
    assign last = ~hi_pend_q;

    always_ff @(posedge CLK) begin
        if (RST || abort) begin
            tx_data   <= '0;
            tx_valid  <= 1'b0;
            hi_q      <= '0;
            hi_pend_q <= 1'b0;
        end else if (load) begin
            tx_data   <= load_data[DATA_WIDTH-1:0];
            hi_q      <= load_data[2*DATA_WIDTH-1:DATA_WIDTH];
            hi_pend_q <= two_byte;
            tx_valid  <= 1'b1;
        end else if (xfer) begin
            if (hi_pend_q) begin
                tx_data   <= hi_q;
                hi_pend_q <= 1'b0;
            end else begin
                tx_valid  <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/sys_cmd_decoder.sv
// Command frame decoder driving register-file and ALU operations from synchronized RX
// bytes. Define CMD_TIMEOUT_EN to abort stalled frames after TIMEOUT_CYCLES.
module sys_cmd_decoder
    import sys_cmd_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned ADDR_WIDTH     = 4,
    parameter int unsigned ALU_OUT_WIDTH  = 16,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [DATA_WIDTH-1:0]    rx_data,
    input  logic                     rx_valid,
    output logic                     rf_wr_en,
    output logic                     rf_rd_en,
    output logic [ADDR_WIDTH-1:0]    rf_addr,
    output logic [DATA_WIDTH-1:0]    rf_wr_data,
    input  logic [DATA_WIDTH-1:0]    rf_rd_data,
    input  logic                     rf_rd_valid,
    output logic [3:0]               alu_fun,
    output logic                     alu_en,
    output logic                     alu_clk_en,
    input  logic [ALU_OUT_WIDTH-1:0] alu_out,
    input  logic                     alu_out_valid,
    output logic [DATA_WIDTH-1:0]    tx_data,
    output logic                     tx_valid,
    input  logic                     tx_ready,
    output logic                     cmd_err
);

    state_t                  state_q, state_d;
    logic                    rf_wr_en_d, rf_rd_en_d, alu_en_d, alu_clk_en_d, cmd_err_d;
    logic [ADDR_WIDTH-1:0]   rf_addr_d;
    logic [DATA_WIDTH-1:0]   rf_wr_data_d;
    logic [3:0]              alu_fun_d;
    logic                    rsp_load, rsp_two;
    logic [2*DATA_WIDTH-1:0] rsp_data;
    logic                    tx_xfer, tx_last;
    logic                    tmo_hit;

`ifdef CMD_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES);

    logic [TMO_W-1:0] tmo_cnt;
    logic             byte_acc;

    assign byte_acc = rx_valid && (state_q inside {ST_WR_ADDR, ST_WR_DATA, ST_RD_ADDR,
                                                   ST_ALU_A, ST_ALU_B, ST_ALU_FUN});
    assign tmo_hit  = (state_q != ST_IDLE) && (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge CLK) begin
        if (RST || state_q == ST_IDLE || byte_acc || state_d != state_q) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        rf_wr_en_d   = 1'b0;
        rf_rd_en_d   = 1'b0;
        alu_en_d     = 1'b0;
        cmd_err_d    = 1'b0;
        rf_addr_d    = rf_addr;
        rf_wr_data_d = rf_wr_data;
        alu_fun_d    = alu_fun;
        alu_clk_en_d = alu_clk_en;
        rsp_load     = 1'b0;
        rsp_two      = 1'b0;
        rsp_data     = '0;

        case (state_q)
            ST_IDLE: if (rx_valid) begin
                case (rx_data)
                    OP_WR:      state_d = ST_WR_ADDR;
                    OP_RD:      state_d = ST_RD_ADDR;
                    OP_ALU_AB:  state_d = ST_ALU_A;
                    OP_ALU_FUN: begin
                        state_d      = ST_ALU_FUN;
                        alu_clk_en_d = 1'b1;
                    end
                    default:    cmd_err_d = 1'b1;
                endcase
            end
            ST_WR_ADDR: if (rx_valid) begin
                rf_addr_d = rx_data[ADDR_WIDTH-1:0];
                state_d   = ST_WR_DATA;
            end
            ST_WR_DATA: if (rx_valid) begin
                rf_wr_data_d = rx_data;
                rf_wr_en_d   = 1'b1;
                state_d      = ST_IDLE;
            end
            ST_RD_ADDR: if (rx_valid) begin
                rf_addr_d  = rx_data[ADDR_WIDTH-1:0];
                rf_rd_en_d = 1'b1;
                state_d    = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                cmd_err_d = rx_valid;
                if (rf_rd_valid) begin
                    rsp_load = 1'b1;
                    rsp_data = (2*DATA_WIDTH)'(rf_rd_data);
                    state_d  = ST_TX_LO;
                end
            end
            ST_ALU_A: if (rx_valid) begin
                rf_addr_d    = ADDR_WIDTH'(ALU_A_ADDR);
                rf_wr_data_d = rx_data;
                rf_wr_en_d   = 1'b1;
                state_d      = ST_ALU_B;
            end
            ST_ALU_B: if (rx_valid) begin
                rf_addr_d    = ADDR_WIDTH'(ALU_B_ADDR);
                rf_wr_data_d = rx_data;
                rf_wr_en_d   = 1'b1;
                alu_clk_en_d = 1'b1;
                state_d      = ST_ALU_FUN;
            end
            ST_ALU_FUN: if (rx_valid) begin
                alu_fun_d = rx_data[3:0];
                alu_en_d  = 1'b1;
                state_d   = ST_ALU_WAIT;
            end
            ST_ALU_WAIT: begin
                cmd_err_d = rx_valid;
                if (alu_out_valid) begin
                    rsp_load     = 1'b1;
                    rsp_two      = 1'b1;
                    rsp_data     = (2*DATA_WIDTH)'(alu_out);
                    alu_clk_en_d = 1'b0;
                    state_d      = ST_TX_LO;
                end
            end
            ST_TX_LO: begin
                cmd_err_d = rx_valid;
                if (tx_xfer) state_d = tx_last ? ST_IDLE : ST_TX_HI;
            end
            ST_TX_HI: begin
                cmd_err_d = rx_valid;
                if (tx_xfer) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // A stalled frame is abandoned outright; any strobe it would have raised is suppressed.
        if (tmo_hit) begin
            state_d      = ST_IDLE;
            cmd_err_d    = 1'b1;
            alu_clk_en_d = 1'b0;
            rf_wr_en_d   = 1'b0;
            rf_rd_en_d   = 1'b0;
            alu_en_d     = 1'b0;
            rsp_load     = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= ST_IDLE;
            rf_wr_en   <= 1'b0;
            rf_rd_en   <= 1'b0;
            rf_addr    <= '0;
            rf_wr_data <= '0;
            alu_fun    <= '0;
            alu_en     <= 1'b0;
            alu_clk_en <= 1'b0;
            cmd_err    <= 1'b0;
        end else begin
            state_q    <= state_d;
            rf_wr_en   <= rf_wr_en_d;
            rf_rd_en   <= rf_rd_en_d;
            rf_addr    <= rf_addr_d;
            rf_wr_data <= rf_wr_data_d;
            alu_fun    <= alu_fun_d;
            alu_en     <= alu_en_d;
            alu_clk_en <= alu_clk_en_d;
            cmd_err    <= cmd_err_d;
        end
    end

    sys_cmd_resp_tx #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_resp_tx (
        .CLK      (CLK),
        .RST      (RST),
        .load     (rsp_load),
        .two_byte (rsp_two),
        .load_data(rsp_data),
        .abort    (tmo_hit),
        .tx_ready (tx_ready),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .xfer     (tx_xfer),
        .last     (tx_last)
    );

endmodule

// File: tb/tb_sys_cmd_decoder.sv
// Self-checking bench for sys_cmd_decoder: directed frames followed by random frames,
// each compared against expectations derived from the frame bytes alone.
module tb_sys_cmd_decoder;

    localparam int unsigned TMO = 1024;

    logic        CLK = 1'b0;
    logic        RST;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rf_wr_en, rf_rd_en;
    logic [3:0]  rf_addr;
    logic [7:0]  rf_wr_data;
    logic [7:0]  rf_rd_data;
    logic        rf_rd_valid;
    logic [3:0]  alu_fun;
    logic        alu_en, alu_clk_en;
    logic [15:0] alu_out;
    logic        alu_out_valid;
    logic [7:0]  tx_data;
    logic        tx_valid, tx_ready;
    logic        cmd_err;

    int checks   = 0;
    int failures = 0;
    int err_cnt  = 0;

    logic [11:0] wr_q[$];
    logic [3:0]  rd_q[$];
    logic [3:0]  fun_q[$];
    logic [7:0]  tx_q[$];

    sys_cmd_decoder #(
        .DATA_WIDTH    (8),
        .ADDR_WIDTH    (4),
        .ALU_OUT_WIDTH (16),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rf_wr_en     (rf_wr_en),
        .rf_rd_en     (rf_rd_en),
        .rf_addr      (rf_addr),
        .rf_wr_data   (rf_wr_data),
        .rf_rd_data   (rf_rd_data),
        .rf_rd_valid  (rf_rd_valid),
        .alu_fun      (alu_fun),
        .alu_en       (alu_en),
        .alu_clk_en   (alu_clk_en),
        .alu_out      (alu_out),
        .alu_out_valid(alu_out_valid),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .cmd_err      (cmd_err)
    );

    always #5 CLK = ~CLK;

    // Inputs change 2ns after the rising edge, so the falling edge sees settled values.
    always @(negedge CLK) begin
        if (rf_wr_en)            wr_q.push_back({rf_addr, rf_wr_data});
        if (rf_rd_en)            rd_q.push_back(rf_addr);
        if (alu_en)              fun_q.push_back(alu_fun);
        if (tx_valid && tx_ready) tx_q.push_back(tx_data);
        if (cmd_err)             err_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
        repeat ($urandom_range(1, 3)) tick();
    endtask

    task automatic clear_mon();
        wr_q.delete();
        rd_q.delete();
        fun_q.delete();
        tx_q.delete();
        err_cnt = 0;
    endtask

    task automatic run_frame(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b,
                             input logic [7:0] f, input int unsigned lat, input int unsigned stall,
                             input bit drop, input logic [15:0] resp);
        logic [11:0] e_wr[$];
        logic [3:0]  e_rd[$];
        logic [3:0]  e_fun[$];
        logic [7:0]  e_tx[$];
        logic [7:0]  bytes[$];
        int          e_err;
        bit          is_rd, is_alu;
        int unsigned n;

        e_err  = 0;
        is_rd  = (op == 8'hBB);
        is_alu = (op == 8'hCC) || (op == 8'hDD);
        bytes.push_back(op);
        case (op)
            8'hAA: begin
                bytes.push_back(a); bytes.push_back(b);
                e_wr.push_back({a[3:0], b});
            end
            8'hBB: begin
                bytes.push_back(a);
                e_rd.push_back(a[3:0]);
                e_tx.push_back(resp[7:0]);
            end
            8'hCC: begin
                bytes.push_back(a); bytes.push_back(b); bytes.push_back(f);
                e_wr.push_back({4'd0, a});
                e_wr.push_back({4'd1, b});
                e_fun.push_back(f[3:0]);
                e_tx.push_back(resp[7:0]);
                e_tx.push_back(resp[15:8]);
            end
            8'hDD: begin
                bytes.push_back(a);
                e_fun.push_back(a[3:0]);
                e_tx.push_back(resp[7:0]);
                e_tx.push_back(resp[15:8]);
            end
            default: e_err = 1;
        endcase
        if (drop && (is_rd || is_alu)) e_err++;

        clear_mon();
        foreach (bytes[i]) send_byte(bytes[i]);

        if (is_rd || is_alu) begin
            n = 0;
            while ((is_rd ? rd_q.size() : fun_q.size()) == 0 && n < 50) begin
                tick();
                n++;
            end
            if (is_rd) check("rd_en_seen", 32'(rd_q.size() != 0), 1);
            else       check("alu_en_seen", 32'(fun_q.size() != 0), 1);
            if (drop) send_byte(8'($urandom));
            repeat (lat) tick();
            if (is_alu) check("alu_clk_en_wait", alu_clk_en, 1);
            if (is_rd) begin
                rf_rd_data  = resp[7:0];
                rf_rd_valid = 1'b1;
            end else begin
                alu_out       = resp;
                alu_out_valid = 1'b1;
            end
            tick();
            rf_rd_valid   = 1'b0;
            alu_out_valid = 1'b0;
            rf_rd_data    = 8'($urandom);
            alu_out       = 16'($urandom);
            for (int unsigned i = 0; i < stall; i++) begin
                check("bp_valid", tx_valid, 1);
                check("bp_data", tx_data, e_tx[0]);
                tick();
            end
            n = 0;
            while (tx_q.size() < e_tx.size() && n < 200) begin
                tx_ready = ($urandom_range(0, 2) != 0);
                tick();
                n++;
            end
            check("tx_in_time", 32'(n < 200), 1);
        end

        // Stray completions while idle must be ignored.
        rf_rd_valid   = 1'b1;
        alu_out_valid = 1'b1;
        tick();
        rf_rd_valid   = 1'b0;
        alu_out_valid = 1'b0;
        tx_ready      = 1'b1;
        repeat (4) tick();
        tx_ready      = 1'b0;

        check("wr_count", wr_q.size(), e_wr.size());
        for (int i = 0; i < e_wr.size() && i < wr_q.size(); i++) check("wr_entry", wr_q[i], e_wr[i]);
        check("rd_count", rd_q.size(), e_rd.size());
        for (int i = 0; i < e_rd.size() && i < rd_q.size(); i++) check("rd_addr", rd_q[i], e_rd[i]);
        check("fun_count", fun_q.size(), e_fun.size());
        for (int i = 0; i < e_fun.size() && i < fun_q.size(); i++) check("alu_fun", fun_q[i], e_fun[i]);
        check("tx_count", tx_q.size(), e_tx.size());
        for (int i = 0; i < e_tx.size() && i < tx_q.size(); i++) check("tx_byte", tx_q[i], e_tx[i]);
        check("err_count", err_cnt, e_err);
        check("clk_en_idle", alu_clk_en, 0);
        check("tx_valid_idle", tx_valid, 0);
    endtask

    initial begin
        logic [7:0]  op;
        int unsigned n;

        RST           = 1'b1;
        rx_data       = '0;
        rx_valid      = 1'b0;
        rf_rd_data    = '0;
        rf_rd_valid   = 1'b0;
        alu_out       = '0;
        alu_out_valid = 1'b0;
        tx_ready      = 1'b0;
        repeat (3) tick();
        check("reset_outputs", {rf_wr_en, rf_rd_en, rf_addr, rf_wr_data, alu_fun, alu_en,
                                alu_clk_en, tx_data, tx_valid, cmd_err}, 0);
        RST = 1'b0;
        tick();

        run_frame(8'hAA, 8'h05, 8'h3C, 8'h00, 0, 0, 1'b0, 16'h0000);
        run_frame(8'hBB, 8'h07, 8'h00, 8'h00, 3, 0, 1'b0, 16'h005A);
        run_frame(8'hCC, 8'h12, 8'h34, 8'h02, 2, 0, 1'b0, 16'h1234);
        run_frame(8'hBB, 8'hF9, 8'h00, 8'h00, 1, 10, 1'b0, 16'h00A5);
        run_frame(8'hDD, 8'h07, 8'h00, 8'h00, 1, 10, 1'b0, 16'hC3E1);
        run_frame(8'h55, 8'h00, 8'h00, 8'h00, 0, 0, 1'b0, 16'h0000);
        run_frame(8'hCC, 8'hFE, 8'h01, 8'hFB, 2, 0, 1'b1, 16'hBEEF);
        run_frame(8'hDD, 8'h03, 8'h00, 8'h00, 2, 0, 1'b1, 16'h8001);

        // Reset in the middle of a write frame; the trailing data byte then reads as a bad opcode.
        clear_mon();
        send_byte(8'hAA);
        send_byte(8'h05);
        RST = 1'b1;
        tick();
        check("midframe_reset_outputs", {rf_wr_en, rf_rd_en, rf_addr, rf_wr_data, alu_fun, alu_en,
                                         alu_clk_en, tx_data, tx_valid, cmd_err}, 0);
        RST = 1'b0;
        tick();
        run_frame(8'h3C, 8'h00, 8'h00, 8'h00, 0, 0, 1'b0, 16'h0000);

`ifdef CMD_TIMEOUT_EN
        clear_mon();
        send_byte(8'hBB);
        send_byte(8'h07);
        n = 0;
        while (err_cnt == 0 && n < TMO + 100) begin
            tick();
            n++;
        end
        check("tmo_err", err_cnt, 1);
        check("tmo_window", 32'(n + 10 > TMO && n < TMO + 10), 1);
        check("tmo_rd_en", rd_q.size(), 1);
        check("tmo_tx_valid", tx_valid, 0);
        run_frame(8'hAA, 8'h09, 8'h77, 8'h00, 0, 0, 1'b0, 16'h0000);
`endif

        for (int k = 0; k < 40; k++) begin
            case ($urandom_range(0, 4))
                0:       op = 8'hAA;
                1:       op = 8'hBB;
                2:       op = 8'hCC;
                3:       op = 8'hDD;
                default: begin
                    op = 8'($urandom);
                    while (op inside {8'hAA, 8'hBB, 8'hCC, 8'hDD}) op = 8'($urandom);
                end
            endcase
            run_frame(op, 8'($urandom), 8'($urandom), 8'($urandom), $urandom_range(0, 5),
                      $urandom_range(0, 3), 1'($urandom_range(0, 1)), 16'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
